rr_resource_arbiter: RTL and testbench
======================================

Name: rr_resource_arbiter

Overview:
Round-robin arbiter that shares one whitebox datapath resource between N_REQ requesters in the same clock domain. The grant is held until the owner drops its request or pulses done. A one-cycle turnaround follows every grant. Sits between requesting blocks and the shared resource's enable/select inputs, all on clk.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must satisfy 2**ID_W >= N_REQ
HOLD_MAX, 8, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined

Ports:
clk  input  1  sole clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  request vector, one bit per requester, level-sensitive
done  input  1  owner finished; sampled only in GRANT
grant  output  N_REQ  one-hot grant to the current owner; all zero when none
grant_valid  output  1  high while any grant bit is set
grant_id  output  ID_W  binary index of the current owner; 0 when no grant
busy  output  1  high in GRANT or TURN
timeout  output  1  sticky timeout flag; tied 0 when ARB_TIMEOUT_EN is undefined

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; grant=0, grant_valid=0, grant_id=0, busy=0, timeout=0.
  - Priority pointer ptr=0.
  - Deassertion takes effect on the next rising clk.
- States:
  - IDLE: if req!=0, pick the winner and go to GRANT. Registered outputs update on the same edge, so latency from req to grant is 1 cycle.
  - GRANT: grant[owner]=1, busy=1.
    - Leave when req[owner]==0, or done==1, or a timeout fires (optional feature).
    - On leave: go to TURN; grant=0, grant_valid=0, grant_id=0; ptr=(owner+1) mod N_REQ.
  - TURN: busy=1, no grant for exactly one cycle, then go to IDLE. A request that is pending during TURN is granted on the IDLE edge.
    - Minimum gap between successive grants: 2 idle-grant cycles (GRANT exit -> TURN -> IDLE -> GRANT).
- Winner selection: scan ptr, ptr+1, ... mod N_REQ; the first set req bit wins. ptr changes only on GRANT exit.
- Request changes during GRANT: only req[owner] is sampled. Other requests rising or falling have no effect.
- done==1 in IDLE or TURN: ignored.
- done and req[owner] falling in the same cycle: one exit, one TURN.
- Single requester holding req continuously: granted, released on done, TURN, then re-granted. ptr wrapping back to itself is legal.
- grant is always one-hot or zero. grant_id equals the encoded grant.
- Reset asserted mid-GRANT: grant drops immediately (asynchronous); ptr returns to 0.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A grant-length counter of width clog2(HOLD_MAX)+1 counts cycles in GRANT, starting at 1 on the entry cycle.
  - When the count reaches HOLD_MAX with req[owner] still high and done low, a forced exit occurs: same transition as a normal exit, and timeout is set.
  - timeout is sticky until reset. The counter clears in TURN.
- Undefined: no counter, grants are unbounded, timeout is constant 0.

Test Plan:
- Reset, then req=4'b0000 for 10 cycles -> grant=0, busy=0, grant_id=0 throughout.
- req=4'b0101 from reset -> requester 0 granted 1 cycle later. Pulse done -> TURN (1 cycle) -> requester 2 granted, grant_id=2, ptr=3 after its release.
- Round-robin with all requests held and done pulsed 3 cycles after each grant -> grant order 0,1,2,3,0; 1 TURN cycle between each grant.
- Owner 1 drops req while req[3] toggles mid-grant -> exit only on req[1] fall. Toggling req[3] has no effect during the grant.
- rst_n low for 1 cycle mid-GRANT of requester 2 -> grant=0 asynchronously. After release with req=4'b1111 -> requester 0 granted.
- With ARB_TIMEOUT_EN, HOLD_MAX=8, req[1] held high and done=0 -> grant lasts exactly 8 cycles, then timeout=1 stays high. Next owner is 2 if req[2]=1. Without the macro, the grant persists for 50+ cycles and timeout=0.

Source files
------------

// File: rtl/rr_resource_arbiter.sv
// ---------------------------------------------------------------------------
// rr_resource_arbiter
//
// Round-robin arbiter that shares one datapath resource between N_REQ
// requesters on a single clock. A grant is held until its owner drops its
// request or pulses done. After every grant there is one TURN cycle with no
// owner, then an IDLE cycle in which the next winner is picked.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a grant that lasts HOLD_MAX cycles with its request still
//   high and done low is forced off, and the sticky timeout flag is set.
//   When undefined, grants are unbounded and timeout is constant 0.
//
// Parameters
//   N_REQ     number of requesters (2..8)
//   ID_W      width of grant_id, 2**ID_W >= N_REQ
//   HOLD_MAX  maximum grant length in cycles (ARB_TIMEOUT_EN only)
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          level-sensitive request vector, one bit per requester
//   done         owner finished; only looked at while a grant is held
//   grant        one-hot grant to the current owner, zero when none
//   grant_valid  high while any grant bit is set
//   grant_id     binary index of the current owner, zero when none
//   busy         high while a grant is held or during the TURN cycle
//   timeout      sticky forced-release flag
// ---------------------------------------------------------------------------
module rr_resource_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             timeout
);

  // Elaboration-time sanity checks on the configuration.
  if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_n_req
    $error("rr_resource_arbiter: N_REQ must be in 2..8");
  end
  if ((2 ** ID_W) < N_REQ) begin : g_bad_id_w
    $error("rr_resource_arbiter: ID_W too narrow for N_REQ");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("rr_resource_arbiter: HOLD_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              busy_q, busy_d;

  logic              win_found_s;
  logic [ID_W-1:0]   win_idx_s;
  logic              owner_req_s;
  logic              timeout_fire_s;
  logic              exit_s;

  // Index base+off folded back into 0..N_REQ-1 (off is always < N_REQ).
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int              off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum + 0;
    end
    return ID_W'(sum);
  endfunction

  // One-hot vector with only bit idx set.
  function automatic logic [N_REQ-1:0] to_onehot(input logic [ID_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Successor of an owner index, used as the next priority pointer.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
    logic [ID_W-1:0] nxt;
    if (idx == ID_W'(N_REQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + ID_W'(1);
    end
    return nxt;
  endfunction

  // Round-robin winner: first set request scanning from ptr upward, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found_s && req[wrap_idx(ptr_q, i)]) begin
        win_found_s = 1'b1;
        win_idx_s   = wrap_idx(ptr_q, i);
      end else begin
        // An earlier candidate in scan order keeps priority.
      end
    end
  end

  // Only the owner's own request bit matters while a grant is held.
  assign owner_req_s = req[owner_q];

  // Release condition: owner drops its request, signals done, or times out.
  assign exit_s = (state_q == ST_GRANT) &&
                  (!owner_req_s || done || timeout_fire_s);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Forced release only when nothing else would have ended the grant.
  assign timeout_fire_s = (state_q == ST_GRANT) &&
                          (cnt_q == CNT_W'(HOLD_MAX)) &&
                          owner_req_s && !done;

  // Grant-length counter: 1 on the first grant cycle, cleared outside GRANT.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q | timeout_fire_s;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          cnt_d = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (exit_s) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TURN: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Counter and sticky timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_fire_s = 1'b0;
  assign timeout        = 1'b0;
`endif

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    busy_d        = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d       = ST_GRANT;
          owner_d       = win_idx_s;
          grant_d       = to_onehot(win_idx_s);
          grant_valid_d = 1'b1;
          grant_id_d    = win_idx_s;
          busy_d        = 1'b1;
        end else begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_id_d    = '0;
          busy_d        = 1'b0;
        end
      end
      ST_GRANT: begin
        if (exit_s) begin
          state_d       = ST_TURN;
          ptr_d         = next_ptr(owner_q);
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_id_d    = '0;
          busy_d        = 1'b1;
        end else begin
          state_d       = ST_GRANT;
        end
      end
      ST_TURN: begin
        // Exactly one dead cycle; the IDLE cycle that follows arbitrates.
        state_d       = ST_IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
        busy_d        = 1'b0;
      end
      default: begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
        busy_d        = 1'b0;
      end
    endcase
  end

  // FSM state, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
module tb_rr_resource_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int HM = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          timeout;

  always #5 clk = ~clk;

  rr_resource_arbiter #(.N_REQ(N), .ID_W(IW), .HOLD_MAX(HM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout     (timeout)
  );

  // Expected grant: owner id, length in cycles (0 = unchecked),
  // idle cycles since the previous grant (0 = unchecked).
  typedef struct {
    int id;
    int len;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input int len, input int gap);
    exp_t e;
    e.id  = id;
    e.len = len;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called in the first cycle of a grant: hold for n cycles, done on the last.
  task automatic grant_for(input int n);
    if (n > 1) cyc(n - 1);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per grant and checks it while it lasts.
  initial begin : monitor
    exp_t cur;
    bit   in_grant;
    bit   gap_known;
    int   len;
    int   gap;
    in_grant  = 1'b0;
    gap_known = 1'b0;
    len       = 0;
    gap       = 0;
    cur.id = -1; cur.len = 0; cur.gap = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_grant  = 1'b0;
        gap_known = 1'b0;
      end else begin
        if (grant_valid && !in_grant) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_grant: got id %0d expected no grant at %0t", grant_id, $time);
            cur.id = -1; cur.len = 0; cur.gap = 0;
          end else begin
            cur = exp_q.pop_front();
            check("grant_id_start", grant_id, cur.id);
            if (cur.gap != 0 && gap_known) check("grant_gap", gap, cur.gap);
          end
          in_grant = 1'b1;
          len      = 1;
        end else if (grant_valid) begin
          len++;
        end else if (in_grant) begin
          if (cur.len != 0) check("grant_len", len, cur.len);
          in_grant  = 1'b0;
          gap_known = 1'b1;
          gap       = 1;
        end else begin
          gap++;
        end
        if (in_grant && cur.id >= 0) begin
          check("grant_vec", grant, 32'd1 << cur.id);
          check("grant_id_hold", grant_id, cur.id);
          check("busy_in_grant", busy, 1);
        end else if (!in_grant) begin
          check("grant_zero", grant, 0);
          check("grant_id_zero", grant_id, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    cyc(2);
    check("rst_grant", grant, 0);
    check("rst_valid", grant_valid, 0);
    check("rst_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;

    // No requests: everything stays quiet.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_grant", grant, 0);
      check("idle_busy", busy, 0);
      check("idle_id", grant_id, 0);
    end
    cyc(1);

    // req=0101: 0 first, then 2; ptr=3 afterwards so 3 beats 0.
    push(0, 3, 0);
    push(2, 3, 2);
    push(3, 3, 2);
    req = 4'b0101;
    #3;
    check("latency_pre_edge", grant, 0);
    cyc(1);
    check("latency_one_cycle", grant, 4'b0001);
    grant_for(3);
    check("turn_busy", busy, 1);
    check("turn_grant", grant, 0);
    cyc(1);
    check("idle_after_turn_busy", busy, 0);
    cyc(1);
    check("second_owner", grant_id, 2);
    req = 4'b1101;
    grant_for(3);
    cyc(2);
    check("ptr_after_owner2", grant_id, 3);
    cyc(2);
    done = 1'b1;
    req  = 4'b0000;
    cyc(1);
    done = 1'b0;
    check("joint_exit_turn_busy", busy, 1);
    cyc(1);
    check("joint_exit_idle_busy", busy, 0);
    cyc(3);
    check("s1_queue_empty", exp_q.size(), 0);

    // All requests held: strict 0,1,2,3,0 rotation.
    do_reset();
    push(0, 3, 0);
    push(1, 3, 2);
    push(2, 3, 2);
    push(3, 3, 2);
    push(0, 3, 2);
    req = 4'b1111;
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      grant_for(3);
      if (k < 4) cyc(2);
    end
    req = 4'b0000;
    cyc(4);
    check("rr_queue_empty", exp_q.size(), 0);

    // Owner 1 with req[3] toggling: release only on req[1] falling.
    do_reset();
    push(1, 5, 0);
    push(3, 2, 2);
    req = 4'b0010;
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      req[3] = ~req[3];
      cyc(1);
    end
    req = 4'b1000;
    cyc(3);
    grant_for(2);
    req = 4'b0000;
    cyc(3);
    check("toggle_queue_empty", exp_q.size(), 0);

    // Reset in the middle of owner 2's grant (ptr was 2 at that point).
    do_reset();
    push(1, 2, 0);
    push(2, 0, 2);
    push(0, 2, 0);
    req = 4'b0110;
    cyc(1);
    grant_for(2);
    cyc(2);
    check("pre_reset_owner", grant_id, 2);
    cyc(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_valid", grant_valid, 0);
    check("async_rst_busy", busy, 0);
    req = 4'b1111;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);
    check("ptr_reset_owner", grant_id, 0);
    grant_for(2);
    req = 4'b0000;
    cyc(3);
    check("rst_queue_empty", exp_q.size(), 0);

    // Long hold by requester 1 with requester 2 waiting.
    do_reset();
`ifdef ARB_TIMEOUT_EN
    push(1, HM, 0);
    push(2, 3, 2);
    req = 4'b0110;
    cyc(1);
    check("to_flag_early", timeout, 0);
    cyc(HM - 1);
    check("to_last_cycle_grant", grant, 4'b0010);
    check("to_flag_last_cycle", timeout, 0);
    cyc(1);
    check("to_flag_set", timeout, 1);
    check("to_released", grant, 0);
    cyc(2);
    check("to_next_owner", grant_id, 2);
    grant_for(3);
    req = 4'b0000;
    cyc(3);
    check("to_flag_sticky", timeout, 1);
`else
    push(1, 55, 0);
    push(2, 3, 2);
    req = 4'b0110;
    cyc(1);
    for (int i = 0; i < 54; i++) begin
      if (i % 18 == 0) check("no_timeout_flag", timeout, 0);
      cyc(1);
    end
    check("long_grant_held", grant, 4'b0010);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    check("no_timeout_after", timeout, 0);
    cyc(2);
    check("long_next_owner", grant_id, 2);
    grant_for(3);
    req = 4'b0000;
    cyc(3);
`endif
    cyc(2);
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
